cbfp_blk_ctrl: RTL and testbench
================================

Name: cbfp_blk_ctrl

Overview:
- Block-exponent controller and normaliser for the CBFP stage.
- Accepts 16-lane I/Q FFT output beats and drives push/pop/data of the downstream cbfp_shift_reg.
- Computes each block's minimum leading-redundant-sign-bit count (block exponent) while the block fills the shift register.
- Left-shifts each drained beat by that exponent and outputs it with the exponent.

Parameters:
DATA_WIDTH, 9, signed sample width, I and Q
NUM_IN_OUT, 16, lanes per beat
BLOCK_LEN, 16, beats per block; must equal shift-register REG_DEPTH
EXP_WIDTH, 4, exponent width; must satisfy 2^EXP_WIDTH > DATA_WIDTH-1

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active high
in_valid  in  1  input beat valid
in_ready  out  1  input accepted when high; registered
flush  in  1  level request to drain the last block with zero padding
din_i/din_q  in  [NUM_IN_OUT] x DATA_WIDTH signed  input beat
sr_valid  out  1  shift-register push (comb)
sr_pop  out  1  shift-register pop (comb)
sr_din_i/sr_din_q  out  [NUM_IN_OUT] x DATA_WIDTH  shift-register data (comb)
sr_dout_i/sr_dout_q  in  [NUM_IN_OUT] x DATA_WIDTH signed  shift-register tail (valid while sr_pop)
dout_i/dout_q  out  [NUM_IN_OUT] x DATA_WIDTH signed  normalised beat
dout_valid  out  1  dout valid
dout_first  out  1  first beat of an output block
blk_exp  out  EXP_WIDTH  exponent of the block currently on dout

Behaviour:
- Interface decision: one clock `clk`; `rst` is asynchronous, active high.
- Reset: state=FILL, cnt=0, in_ready=1, dout_*=0, dout_valid=0, dout_first=0, blk_exp=0, run_min=DATA_WIDTH-1.
- Accept: beat accepted when in_valid && in_ready.
- Lane metric: lrs(x) = count of bits below the MSB equal to the MSB, range 0..DATA_WIDTH-1.
  - 0 and -1 give DATA_WIDTH-1.
  - e.g. 9'sd3 -> 6, 9'sd255 -> 0, -9'sd256 -> 0.
- Running minimum: run_min = min(run_min, lrs over all 2*NUM_IN_OUT values of every accepted beat).
  - On block completion, run_min is latched into exp_pend and reset to DATA_WIDTH-1.
  - The beat completing the block is included in exp_pend.
- Rule: sr_pop is never asserted without sr_valid, because pop-only reverses shift direction.
- FILL (no old block held):
  - Accepted beat: sr_valid=1, sr_din=din, cnt++.
  - On the beat with cnt==BLOCK_LEN-1: cnt=0, latch exp, go STREAM.
  - No accept: sr_valid=0.
- STREAM (old block held):
  - Accepted beat: sr_valid=1, sr_pop=1, sr_din=din, cnt++.
  - Wrap at BLOCK_LEN-1 latches the new exponent; the old block's exponent is used for the pops of that beat.
  - No accept: no push, no pop; drain stalls and the tail is preserved.
  - flush && cnt==0 && !in_valid: go FLUSH, in_ready deasserts next cycle.
  - flush at cnt!=0 is held off until the block boundary; flush in FILL is ignored.
- FLUSH:
  - Every cycle: sr_valid=1, sr_pop=1, sr_din=0, cnt++.
  - At cnt==BLOCK_LEN-1: cnt=0, go FILL, in_ready=1 next cycle.
  - in_valid ignored.
- Output pipeline, registered, latency 1 from each sr_pop cycle:
  - dout = sr_dout <<< drain_exp, computed in DATA_WIDTH bits; no overflow possible by construction.
  - dout_valid = registered sr_pop.
  - dout_first on the first pop of each block.
  - blk_exp = drain_exp.
  - When no pop: dout held at its last value, dout_valid=0.
- Reset mid-block: all partial counts and exponents discarded. The shift register is expected to be reset by the same rst, inverted.

Optional Feature:
CBFP_OVF_FLAG_EN:
- Defined: adds output `proto_err` (1 bit, sticky, reset 0), set when in_valid && !in_ready, or when flush is asserted in FILL with cnt!=0.
- Undefined: port absent; violations silently dropped or ignored as above.

Decomposition:
- Package cbfp_pkg holds:
  - DATA_WIDTH, NUM_IN_OUT, BLOCK_LEN, EXP_WIDTH defaults.
  - State enum {FILL, STREAM, FLUSH}.
  - Function lrs().
- Sub-module cbfp_min_lrs: combinational min-lrs over 2*NUM_IN_OUT values (balanced tree), instantiated once.

Test Plan:
1. 16 beats, all lanes 9'sd3 -> no pops during fill; then 16 more beats of 9'sd100 -> dout=9'sd192 for all lanes, blk_exp=6, dout_first on the 1st, 16 dout_valid total.
2. One lane holds -9'sd256 on beat 7, rest 9'sd1 -> blk_exp=0, outputs unshifted; the following all-zero block -> blk_exp=8, dout=0.
3. in_valid gaps of 3 cycles every other beat in STREAM -> sr_pop only with sr_valid, dout order preserved, no duplicated or lost beats.
4. Two full blocks, then flush=1 with in_valid=0 -> 16 zero pushes, second block drained exactly, in_ready low 16 cycles, state returns FILL.
5. flush asserted at cnt=5 -> honoured only after 11 more beats; in_valid during FLUSH (with CBFP_OVF_FLAG_EN) -> proto_err=1.
6. rst pulsed at cnt=9 in STREAM -> all outputs 0 same cycle; next 16 beats treated as a fresh FILL with no pops.

Source files
------------

// File: rtl/cbfp_pkg.sv
// Shared types, default sizes and the lane leading-redundant-sign-bit metric
// for the CBFP block-exponent controller.
package cbfp_pkg;

   localparam int DATA_WIDTH = 9;
   localparam int NUM_IN_OUT = 16;
   localparam int BLOCK_LEN  = 16;
   localparam int EXP_WIDTH  = 4;
   localparam int CNT_WIDTH  = $clog2(BLOCK_LEN);

   typedef logic signed [DATA_WIDTH-1:0] samp_t;
   typedef samp_t [NUM_IN_OUT-1:0]       beat_t;
   typedef logic [EXP_WIDTH-1:0]         exp_t;

   typedef enum logic [1:0] {FILL, STREAM, FLUSH} state_t;

   // Number of bits directly below the MSB that repeat the MSB (0 and -1 give DATA_WIDTH-1).
   function automatic exp_t lrs(input samp_t x);
      exp_t n;
      logic run;
      n   = '0;
      run = 1'b1;
      for (int i = DATA_WIDTH-2; i >= 0; i--) begin
         if (run && (x[i] == x[DATA_WIDTH-1])) n = n + 1'b1;
         else run = 1'b0;
      end
      return n;
   endfunction

endpackage

// File: rtl/cbfp_blk_ctrl_if.sv
// Beat input, shift-register side and normalised output bundle of cbfp_blk_ctrl.
// master = upstream/shift-register side, slave = the controller.
interface cbfp_blk_ctrl_if;
   import cbfp_pkg::*;

   logic  in_valid;
   logic  in_ready;
   logic  flush;
   beat_t din_i;
   beat_t din_q;
   logic  sr_valid;
   logic  sr_pop;
   beat_t sr_din_i;
   beat_t sr_din_q;
   beat_t sr_dout_i;
   beat_t sr_dout_q;
   beat_t dout_i;
   beat_t dout_q;
   logic  dout_valid;
   logic  dout_first;
   exp_t  blk_exp;

   modport master (
      output in_valid, flush, din_i, din_q, sr_dout_i, sr_dout_q,
      input  in_ready, sr_valid, sr_pop, sr_din_i, sr_din_q,
             dout_i, dout_q, dout_valid, dout_first, blk_exp
   );

   modport slave (
      input  in_valid, flush, din_i, din_q, sr_dout_i, sr_dout_q,
      output in_ready, sr_valid, sr_pop, sr_din_i, sr_din_q,
             dout_i, dout_q, dout_valid, dout_first, blk_exp
   );

endinterface

// File: rtl/cbfp_min_lrs.sv
// Minimum lrs over all I and Q lanes of one beat, as a balanced binary min-tree.
// Heap layout: node k has children 2k and 2k+1, leaves start at LEAVES
// (so the leaf count must be a power of two).
module cbfp_min_lrs
   import cbfp_pkg::*;
(
   input  beat_t lane_i,
   input  beat_t lane_q,
   output exp_t  min_lrs
);

   localparam int LEAVES = 2*NUM_IN_OUT;

   exp_t node [1:2*LEAVES-1];

   // Leaves get the per-lane metric, each inner node keeps the smaller child.
   always_comb begin
      for (int k = 1; k < 2*LEAVES; k++) node[k] = '0;
      for (int k = 0; k < NUM_IN_OUT; k++) begin
         node[LEAVES+k]            = lrs(lane_i[k]);
         node[LEAVES+NUM_IN_OUT+k] = lrs(lane_q[k]);
      end
      for (int k = LEAVES-1; k >= 1; k--)
         node[k] = (node[2*k] < node[2*k+1]) ? node[2*k] : node[2*k+1];
   end

   assign min_lrs = node[1];

endmodule

// File: rtl/cbfp_blk_ctrl.sv
// CBFP block-exponent controller: fills the external shift register with one
// block while tracking its minimum lrs, then drains the previous block
// left-shifted by its exponent as the next block streams in.
// Optional build macro CBFP_OVF_FLAG_EN adds the sticky proto_err output.
//
// state  | meaning
// FILL   | shift register holds no complete block; pushes only
// STREAM | one complete block held; each accepted beat pushes and pops
// FLUSH  | draining the held block by pushing BLOCK_LEN zero beats
module cbfp_blk_ctrl
   import cbfp_pkg::*;
(
   input  logic clk,
   input  logic rst,
   cbfp_blk_ctrl_if.slave bus
`ifdef CBFP_OVF_FLAG_EN
   ,
   output logic proto_err
`endif
);

   state_t               state, state_nx;
   logic [CNT_WIDTH-1:0] cnt, cnt_nx;
   exp_t                 run_min, exp_pend, beat_min, new_min;
   logic                 accept, blk_last;

   assign accept   = bus.in_valid && bus.in_ready;
   assign blk_last = (cnt == CNT_WIDTH'(BLOCK_LEN-1));
   assign new_min  = (beat_min < run_min) ? beat_min : run_min;

   cbfp_min_lrs u_min_lrs (
      .lane_i  (bus.din_i),
      .lane_q  (bus.din_q),
      .min_lrs (beat_min)
   );

   // Next state, beat counter and shift-register push/pop; pop always rides with a push.
   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      bus.sr_valid = 1'b0;
      bus.sr_pop   = 1'b0;
      bus.sr_din_i = '0;
      bus.sr_din_q = '0;
      case (state)
         FILL: begin
            if (accept) begin
               bus.sr_valid = 1'b1;
               bus.sr_din_i = bus.din_i;
               bus.sr_din_q = bus.din_q;
               cnt_nx       = cnt + 1'b1;
               if (blk_last) begin
                  cnt_nx   = '0;
                  state_nx = STREAM;
               end
            end
         end
         STREAM: begin
            if (accept) begin
               bus.sr_valid = 1'b1;
               bus.sr_pop   = 1'b1;
               bus.sr_din_i = bus.din_i;
               bus.sr_din_q = bus.din_q;
               cnt_nx       = cnt + 1'b1;
               if (blk_last) cnt_nx = '0;
            end else if (bus.flush && (cnt == '0) && !bus.in_valid) begin
               state_nx = FLUSH;
            end
         end
         FLUSH: begin
            bus.sr_valid = 1'b1;
            bus.sr_pop   = 1'b1;
            cnt_nx       = cnt + 1'b1;
            if (blk_last) begin
               cnt_nx   = '0;
               state_nx = FILL;
            end
         end
         default: state_nx = FILL;
      endcase
   end

   // State, counter and registered ready (low for exactly the FLUSH cycles).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= FILL;
         cnt          <= '0;
         bus.in_ready <= 1'b1;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         bus.in_ready <= (state_nx != FLUSH);
      end
   end

   // Running minimum of the filling block; latched into exp_pend with the block's last beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_min  <= exp_t'(DATA_WIDTH-1);
         exp_pend <= '0;
      end else if (accept) begin
         if (blk_last) begin
            exp_pend <= new_min;
            run_min  <= exp_t'(DATA_WIDTH-1);
         end else begin
            run_min  <= new_min;
         end
      end
   end

   // Normalise each popped beat; exp_pend still holds the draining block's exponent on its last pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.dout_i     <= '0;
         bus.dout_q     <= '0;
         bus.dout_valid <= 1'b0;
         bus.dout_first <= 1'b0;
         bus.blk_exp    <= '0;
      end else if (bus.sr_pop) begin
         for (int k = 0; k < NUM_IN_OUT; k++) begin
            bus.dout_i[k] <= bus.sr_dout_i[k] <<< exp_pend;
            bus.dout_q[k] <= bus.sr_dout_q[k] <<< exp_pend;
         end
         bus.dout_valid <= 1'b1;
         bus.dout_first <= (cnt == '0);
         bus.blk_exp    <= exp_pend;
      end else begin
         bus.dout_valid <= 1'b0;
         bus.dout_first <= 1'b0;
      end
   end

`ifdef CBFP_OVF_FLAG_EN
   // Sticky flag for beats offered while not ready and flush requests mid-fill.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) proto_err <= 1'b0;
      else if ((bus.in_valid && !bus.in_ready) ||
               (bus.flush && (state == FILL) && (cnt != '0)))
         proto_err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_cbfp_blk_ctrl.sv
// Self-checking bench for cbfp_blk_ctrl: depth-BLOCK_LEN shift-register model,
// block-level reference model feeding an output scoreboard, directed and random blocks.
module tb_cbfp_blk_ctrl;
   import cbfp_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cbfp_blk_ctrl_if bus();
`ifdef CBFP_OVF_FLAG_EN
   logic proto_err;
`endif

   cbfp_blk_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef CBFP_OVF_FLAG_EN
      ,
      .proto_err (proto_err)
`endif
   );

   int n_chk  = 0;
   int n_err  = 0;
   int n_dout = 0;

   task automatic chk_eq(input string tag,
                         input logic [NUM_IN_OUT*DATA_WIDTH-1:0] got,
                         input logic [NUM_IN_OUT*DATA_WIDTH-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- shift register model (fixed depth, tail = oldest) ----------------
   beat_t srq_i[$];
   beat_t srq_q[$];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         srq_i.delete();
         srq_q.delete();
         bus.sr_dout_i <= '0;
         bus.sr_dout_q <= '0;
      end else begin
         if (bus.sr_pop && srq_i.size() > 0) begin
            void'(srq_i.pop_front());
            void'(srq_q.pop_front());
         end
         if (bus.sr_valid) begin
            srq_i.push_back(bus.sr_din_i);
            srq_q.push_back(bus.sr_din_q);
            if (srq_i.size() > BLOCK_LEN) begin
               void'(srq_i.pop_front());
               void'(srq_q.pop_front());
            end
         end
         bus.sr_dout_i <= (srq_i.size() > 0) ? srq_i[0] : '0;
         bus.sr_dout_q <= (srq_q.size() > 0) ? srq_q[0] : '0;
      end
   end

   // ---------------- block reference model ----------------
   typedef struct {
      beat_t di;
      beat_t dq;
      int    e;
      bit    first;
   } sb_ent_t;

   beat_t   cur_i[$];
   beat_t   cur_q[$];
   sb_ent_t sb_q[$];

   // Largest k such that v fits in DATA_WIDTH-k signed bits.
   function automatic int mdl_lrs(input int v);
      for (int k = DATA_WIDTH-1; k >= 0; k--)
         if (v >= -(1 << (DATA_WIDTH-1-k)) && v < (1 << (DATA_WIDTH-1-k))) return k;
      return 0;
   endfunction

   function automatic beat_t mdl_shift(input beat_t b, input int e);
      beat_t r;
      samp_t s;
      for (int k = 0; k < NUM_IN_OUT; k++) begin
         s    = b[k];
         r[k] = samp_t'(int'(s) * (1 << e));
      end
      return r;
   endfunction

   task automatic mdl_accept(input beat_t bi, input beat_t bq);
      int      e;
      int      m;
      beat_t   b;
      samp_t   s;
      sb_ent_t ent;
      cur_i.push_back(bi);
      cur_q.push_back(bq);
      if (cur_i.size() == BLOCK_LEN) begin
         e = DATA_WIDTH-1;
         for (int j = 0; j < BLOCK_LEN; j++) begin
            for (int k = 0; k < NUM_IN_OUT; k++) begin
               b = cur_i[j]; s = b[k]; m = mdl_lrs(int'(s)); if (m < e) e = m;
               b = cur_q[j]; s = b[k]; m = mdl_lrs(int'(s)); if (m < e) e = m;
            end
         end
         for (int j = 0; j < BLOCK_LEN; j++) begin
            ent.di    = mdl_shift(cur_i[j], e);
            ent.dq    = mdl_shift(cur_q[j], e);
            ent.e     = e;
            ent.first = (j == 0);
            sb_q.push_back(ent);
         end
         cur_i.delete();
         cur_q.delete();
      end
   endtask

   // ---------------- output monitor ----------------
   always @(negedge clk) begin : mon
      sb_ent_t ent;
      if (!rst) begin
         chk_eq("pop_needs_push", bus.sr_pop & ~bus.sr_valid, 0);
         if (bus.dout_valid) begin
            n_dout++;
            if (sb_q.size() == 0) begin
               chk_eq("unexpected_dout", bus.dout_valid, 0);
            end else begin
               ent = sb_q.pop_front();
               chk_eq("dout_i", bus.dout_i, ent.di);
               chk_eq("dout_q", bus.dout_q, ent.dq);
               chk_eq("blk_exp", bus.blk_exp, ent.e);
               chk_eq("dout_first", bus.dout_first, ent.first);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input beat_t bi, input beat_t bq);
      logic acc;
      bus.in_valid = 1'b1;
      bus.din_i    = bi;
      bus.din_q    = bq;
      acc          = bus.in_ready;
      tick();
      if (acc) mdl_accept(bi, bq);
      bus.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) tick();
   endtask

   function automatic beat_t fill_beat(input samp_t v);
      beat_t b;
      for (int k = 0; k < NUM_IN_OUT; k++) b[k] = v;
      return b;
   endfunction

   function automatic beat_t rand_beat(input int emin);
      beat_t b;
      int    e;
      int    m;
      for (int k = 0; k < NUM_IN_OUT; k++) begin
         e    = int'($urandom_range(DATA_WIDTH-1, emin));
         m    = 1 << (DATA_WIDTH-1-e);
         b[k] = samp_t'(int'($urandom_range(2*m-1, 0)) - m);
      end
      return b;
   endfunction

   // Flush with in_valid low; optionally offer one beat while FLUSH holds in_ready low.
   task automatic do_flush(input string tag, input bit poke);
      int low;
      low       = 0;
      bus.flush = 1'b1;
      bus.din_i = rand_beat(0);
      bus.din_q = rand_beat(0);
      for (int c = 0; c < 40; c++) begin
         bus.in_valid = poke && (low == 1);
         tick();
         if (!bus.in_ready) low++;
         else if (low > 0) break;
      end
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      chk_eq(tag, low, BLOCK_LEN);
      tick();
      chk_eq({tag, "_drained"}, sb_q.size(), 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      beat_t b;
      int    base;
      int    emin;
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      bus.din_i    = '0;
      bus.din_q    = '0;
      rst          = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_eq("rst_in_ready", bus.in_ready, 1);
      chk_eq("rst_dout_valid", bus.dout_valid, 0);
      chk_eq("rst_blk_exp", bus.blk_exp, 0);
      chk_eq("rst_dout_i", bus.dout_i, 0);
      chk_eq("rst_sr_valid", bus.sr_valid, 0);
      rst = 1'b0;
      tick();

      // 1: all-3 block then all-100 block
      repeat (BLOCK_LEN) send(fill_beat(9'sd3), fill_beat(9'sd3));
      chk_eq("t1_no_fill_pops", n_dout, 0);
      repeat (BLOCK_LEN) send(fill_beat(9'sd100), fill_beat(9'sd100));
      tick();
      chk_eq("t1_outs", n_dout, BLOCK_LEN);
      chk_eq("t1_held", sb_q.size(), BLOCK_LEN);
      chk_eq("t1_dout192", bus.dout_i, fill_beat(9'sd192));
      chk_eq("t1_exp6", bus.blk_exp, 6);

      // 2: one full-scale negative lane, then an all-zero block
      for (int j = 0; j < BLOCK_LEN; j++) begin
         b = fill_beat(9'sd1);
         if (j == 7) b[3] = -9'sd256;
         send(b, fill_beat(9'sd1));
      end
      repeat (BLOCK_LEN) send(fill_beat(9'sd0), fill_beat(9'sd0));
      tick();
      chk_eq("t2_unshifted", bus.dout_i, fill_beat(9'sd1));
      chk_eq("t2_exp0", bus.blk_exp, 0);

      // 3: gaps while streaming drains the zero block
      for (int j = 0; j < BLOCK_LEN; j++) begin
         send(rand_beat(2), rand_beat(2));
         if (j % 2 == 1) idle(3);
      end
      tick();
      chk_eq("t3_zero_out", bus.dout_i, 0);
      chk_eq("t3_exp8", bus.blk_exp, DATA_WIDTH-1);

      // 4: second block then flush; flush in FILL afterwards is ignored
      repeat (BLOCK_LEN) send(rand_beat(1), rand_beat(3));
      do_flush("t4_flush_len", 1'b0);
      bus.flush = 1'b1;
      repeat (3) begin
         tick();
         chk_eq("t4_fill_flush_ignored", bus.in_ready, 1);
      end
      bus.flush = 1'b0;

      // 5: flush raised at cnt=5 is held off to the block boundary
`ifdef CBFP_OVF_FLAG_EN
      chk_eq("t5_proto_err_clear", proto_err, 0);
`endif
      repeat (BLOCK_LEN) send(rand_beat(4), rand_beat(0));
      repeat (5) send(rand_beat(2), rand_beat(5));
      bus.flush = 1'b1;
      for (int j = 0; j < BLOCK_LEN-5; j++) begin
         send(rand_beat(3), rand_beat(3));
         chk_eq("t5_hold_off", bus.in_ready, 1);
      end
      do_flush("t5_flush_len", 1'b1);
`ifdef CBFP_OVF_FLAG_EN
      chk_eq("t5_proto_err", proto_err, 1);
`endif

      // 6: reset at cnt=9 while streaming
      repeat (BLOCK_LEN) send(rand_beat(2), rand_beat(2));
      repeat (9) send(rand_beat(1), rand_beat(1));
      rst = 1'b1;
      #1;
      chk_eq("t6_dout_valid", bus.dout_valid, 0);
      chk_eq("t6_dout_first", bus.dout_first, 0);
      chk_eq("t6_dout_i", bus.dout_i, 0);
      chk_eq("t6_dout_q", bus.dout_q, 0);
      chk_eq("t6_blk_exp", bus.blk_exp, 0);
      chk_eq("t6_in_ready", bus.in_ready, 1);
      cur_i.delete();
      cur_q.delete();
      sb_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst  = 1'b0;
      base = n_dout;
      repeat (BLOCK_LEN) send(rand_beat(0), rand_beat(0));
      tick();
      chk_eq("t6_no_pops", n_dout - base, 0);
      chk_eq("t6_held", sb_q.size(), BLOCK_LEN);

      // random blocks with random exponents and input gaps
      for (int blk = 0; blk < 6; blk++) begin
         emin = int'($urandom_range(DATA_WIDTH-1, 0));
         for (int j = 0; j < BLOCK_LEN; j++) begin
            send(rand_beat(emin), rand_beat(emin + int'($urandom_range(1, 0)) > DATA_WIDTH-1 ?
                                            DATA_WIDTH-1 : emin));
            if ($urandom_range(3, 0) == 0) idle(int'($urandom_range(3, 1)));
         end
      end
      do_flush("rand_flush_len", 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
